// File: rtl/draw_pkg.sv
// draw_pkg: shared FSM state type, buffer base addresses and client indices
// for the draw scheduler.
package draw_pkg;
  typedef enum logic [2:0] {S_IDLE, S_KICK, S_RUN, S_ADVANCE, S_DONE} state_t;
  localparam logic [21:0] WRADDR_OFFSET0 = 22'h100000;
  localparam logic [21:0] WRADDR_OFFSET1 = 22'h200000;
  localparam logic [7:0]  TRANSPARENT    = 8'hFF;
  localparam int CLI_NOTE  = 0;
  localparam int CLI_SCORE = 1;
  localparam int CLI_JUDGE = 2;
endpackage

// File: rtl/draw_scheduler_if.sv
// draw_scheduler_if: draw-client and SDRAM write-port bundle.
//   master: scheduler side (drives client gating and the SDRAM write port)
//   slave : clients + SDRAM controller side
interface draw_scheduler_if #(parameter int N_CLI = 3);
  logic                        sdram_wait, sdram_ac, sdram_wr;
  logic [21:0]                 sdram_addr;
  logic [127:0]                sdram_data;
  logic [15:0]                 sdram_be;
  logic [N_CLI-1:0]            cli_wr, cli_done, cli_new_frame, cli_wait, cli_ac;
  logic [N_CLI-1:0][21:0]      cli_addr;
  logic [N_CLI-1:0][127:0]     cli_data;
  logic [N_CLI-1:0][15:0]      cli_be;
  modport master (
    input  sdram_wait, sdram_ac, cli_wr, cli_addr, cli_data, cli_be, cli_done,
    output cli_new_frame, cli_wait, cli_ac, sdram_wr, sdram_addr, sdram_data, sdram_be
  );
  modport slave (
    output sdram_wait, sdram_ac, cli_wr, cli_addr, cli_data, cli_be, cli_done,
    input  cli_new_frame, cli_wait, cli_ac, sdram_wr, sdram_addr, sdram_data, sdram_be
  );
endinterface

// File: rtl/draw_watchdog.sv
// draw_watchdog: per-grant cycle counter; saturates at TIMEOUT-1 and flags expiry.
//   clr clears, ld loads ld_val, en counts; expired is high at TIMEOUT-1.
module draw_watchdog #(
  parameter logic [19:0] TIMEOUT = 20'd400000,
  localparam int W = $clog2(TIMEOUT)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic         expired
);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 20'd1);
  logic [W-1:0] cnt_q, cnt_d;
  // holding at LAST keeps the flag up while a write in flight delays the skip
  always_comb cnt_d = clr ? '0 : ld ? ld_val : (en && cnt_q != LAST) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expired = cnt_q == LAST;
endmodule

// File: rtl/draw_scheduler.sv
// draw_scheduler: per-frame sequencer and SDRAM write-port arbiter for the draw clients.
//   clk/reset        : clock, asynchronous active-high reset
//   new_frame        : display frame start pulse
//   bus (master)     : client start/wait/ack gating and forwarded SDRAM write port
//   frame_flip       : back-buffer select, toggled at the first new_frame after all clients finish
//   busy             : a frame's draw is in progress
//   overrun_cnt      : saturating count of new_frame pulses that arrived while busy
//   timeout_cnt      : saturating count of clients skipped by the watchdog
module draw_scheduler import draw_pkg::*; #(
  parameter int          N_CLI   = 3,
  parameter logic [19:0] TIMEOUT = 20'd400000,
  parameter int          CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               new_frame,
  draw_scheduler_if.master   bus,
  output logic               frame_flip,
  output logic               busy,
  output logic [CNT_W-1:0]   overrun_cnt,
  output logic [CNT_W-1:0]   timeout_cnt
);
  localparam int GW = N_CLI > 1 ? $clog2(N_CLI) : 1;
  state_t           state_q, state_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic             flip_q, flip_d;
  logic [CNT_W-1:0] ovr_q, ovr_d, tmo_q, tmo_d;
  logic             run, last, cur_wr, cur_done, wd_clr, wd_exp;
  assign run      = state_q == S_RUN;
  assign last     = grant_q == GW'(N_CLI - 1);
  assign cur_wr   = bus.cli_wr[grant_q];
  assign cur_done = bus.cli_done[grant_q];
  assign busy     = state_q == S_KICK || run || state_q == S_ADVANCE;
  draw_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk(clk), .reset(reset), .clr(wd_clr), .en(run), .ld(1'b0), .ld_val('0), .expired(wd_exp)
  );
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    flip_d  = flip_q;
    wd_clr  = 1'b0;
    tmo_d   = tmo_q;
    // a pulse while drawing is only counted; the frame is dropped rather than torn
    ovr_d   = ovr_q + CNT_W'(new_frame && busy && ovr_q != '1);
    case (state_q)
      S_IDLE: state_d = new_frame ? S_KICK : S_IDLE;
      S_KICK: begin
        state_d = S_RUN;
        grant_d = GW'(CLI_NOTE);
        wd_clr  = 1'b1;
      end
      // the grant only moves between writes so an in-flight write always reaches its ack
      S_RUN: if (!cur_wr && (cur_done || wd_exp)) begin
        state_d = S_ADVANCE;
        tmo_d   = tmo_q + CNT_W'(!cur_done && tmo_q != '1);
      end
      S_ADVANCE: begin
        state_d = last ? S_DONE : S_RUN;
        grant_d = last ? grant_q : grant_q + 1'b1;
        wd_clr  = 1'b1;
      end
      S_DONE: if (new_frame) begin
        state_d = S_KICK;
        flip_d  = !flip_q;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    bus.sdram_wr      = run && cur_wr;
    bus.sdram_addr    = run ? bus.cli_addr[grant_q] : '0;
    bus.sdram_data    = run ? bus.cli_data[grant_q] : '0;
    bus.sdram_be      = run ? bus.cli_be[grant_q] : '0;
    bus.cli_new_frame = {N_CLI{state_q == S_KICK}};
    bus.cli_wait      = '1;
    bus.cli_ac        = '0;
    for (int i = 0; i < N_CLI; i++) begin
      bus.cli_wait[i] = bus.sdram_wait || !run || (grant_q != GW'(i));
      bus.cli_ac[i]   = bus.sdram_ac && run && (grant_q == GW'(i));
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      flip_q  <= 1'b0;
      ovr_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      flip_q  <= flip_d;
      ovr_q   <= ovr_d;
      tmo_q   <= tmo_d;
    end
  assign frame_flip  = flip_q;
  assign overrun_cnt = ovr_q;
  assign timeout_cnt = tmo_q;
endmodule

// File: tb/tb_draw_scheduler.sv
// tb_draw_scheduler: directed frames against client/SDRAM models with a write scoreboard.
module tb_draw_scheduler;
  logic       clk, reset, new_frame, frame_flip, busy;
  logic [7:0] overrun_cnt, timeout_cnt;
  draw_scheduler_if #(.N_CLI(3)) bus ();
  draw_scheduler #(.N_CLI(3), .TIMEOUT(20'd100), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .new_frame(new_frame), .bus(bus), .frame_flip(frame_flip),
    .busy(busy), .overrun_cnt(overrun_cnt), .timeout_cnt(timeout_cnt)
  );
  typedef struct {int cli; logic [21:0] a; logic [127:0] d; logic [15:0] be;} wr_t;
  wr_t  exp_q[$];
  int   log_q[$];
  int   nchk = 0, npass = 0, nfail = 0;
  int   seq = 1, age = 0;
  int   left[3];
  bit   hang1 = 0, late = 0;
  logic [2:0] acs, cws;
  wr_t  e;
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input int i);
    wr_t w;
    w.cli = i;
    w.a   = 22'(seq);
    w.d   = {32'(seq) ^ 32'hA5A50000, ~32'(seq), 32'(seq * 3), 32'(i)};
    w.be  = 16'(seq * 7 + 1);
    seq++;
    bus.cli_wr[i]   = 1'b1;
    bus.cli_addr[i] = w.a;
    bus.cli_data[i] = w.d;
    bus.cli_be[i]   = w.be;
    exp_q.push_back(w);
    if (late && i == 0 && left[0] == 1) bus.cli_done[0] = 1'b1;
  endtask
  // clients and SDRAM: sample and react 2 time units after each rising edge
  always @(posedge clk) begin
    #2;
    acs = bus.cli_ac;
    cws = bus.cli_wait;
    if (reset) begin
      bus.cli_wr = '0; bus.cli_done = '0; bus.cli_addr = '0; bus.cli_data = '0; bus.cli_be = '0;
      bus.sdram_ac = 1'b0;
      age = 0;
      left = '{0, 0, 0};
      exp_q.delete();
    end else begin
      if (bus.sdram_ac) begin
        chk("sb_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sb_wr", bus.sdram_wr, 1);
          chk("sb_addr", bus.sdram_addr, e.a);
          chk("sb_data", bus.sdram_data, e.d);
          chk("sb_be", bus.sdram_be, e.be);
          chk("sb_ac", bus.cli_ac, 3'b001 << e.cli);
          log_q.push_back(e.cli);
        end
        bus.sdram_ac = 1'b0;
        age = 0;
      end else if (bus.sdram_wr && !bus.sdram_wait) begin
        age++;
        if (age == 2) begin
          bus.sdram_ac = 1'b1;
          age = 0;
        end
      end else age = 0;
      for (int i = 0; i < 3; i++) begin
        if (bus.cli_new_frame[i]) begin
          left[i] = 10;
          bus.cli_done[i] = 1'b0;
          bus.cli_wr[i] = 1'b0;
        end else if (bus.cli_wr[i]) begin
          if (acs[i]) begin
            left[i]--;
            if (left[i] == 0) begin
              bus.cli_wr[i] = 1'b0;
              bus.cli_done[i] = 1'b1;
            end else issue(i);
          end
        end else if (!bus.cli_done[i] && left[i] != 0 && !cws[i] && !(hang1 && i == 1)) issue(i);
      end
    end
  end
  task automatic pulse();
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
  endtask
  task automatic wait_idle(input int lim);
    int c = 0;
    while (busy && c < lim) begin
      tick();
      c++;
    end
    chk("idle_reached", busy, 0);
    chk("idle_cli_wait", bus.cli_wait, 3'b111);
  endtask
  task automatic wait_grant(input int i);
    int c = 0;
    while (bus.cli_wait[i] && c < 400) begin
      tick();
      c++;
    end
    chk("grant_reached", bus.cli_wait[i], 0);
  endtask
  task automatic check_log(input int n, input bit skip);
    chk("log_len", log_q.size(), n);
    chk("sb_left", exp_q.size(), 0);
    for (int k = 0; k < log_q.size() && k < n; k++)
      chk("log_order", log_q[k], skip ? (k < 10 ? 0 : 2) : k / 10);
  endtask
  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end
  initial begin
    int c, n1;
    reset = 1'b1; new_frame = 1'b0; bus.sdram_wait = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_cli_wait", bus.cli_wait, 3'b111);
    chk("rst_cli_nf", bus.cli_new_frame, 3'b000);
    chk("rst_cli_ac", bus.cli_ac, 3'b000);
    chk("rst_sdram_wr", bus.sdram_wr, 0);
    chk("rst_flip", frame_flip, 0);
    chk("rst_ovr", overrun_cnt, 0);
    chk("rst_tmo", timeout_cnt, 0);
    // frame 1: plain run, no flip on first frame
    log_q.delete();
    pulse();
    chk("f1_kick_nf", bus.cli_new_frame, 3'b111);
    chk("f1_busy", busy, 1);
    chk("f1_flip", frame_flip, 0);
    wait_idle(600);
    check_log(30, 0);
    chk("f1_flip_done", frame_flip, 0);
    // frame 2: flip, then stall client 1 with sdram_wait
    log_q.delete();
    pulse();
    chk("f2_flip", frame_flip, 1);
    chk("f2_kick_nf", bus.cli_new_frame, 3'b111);
    wait_grant(1);
    repeat (4) tick();
    bus.sdram_wait = 1'b1;
    repeat (50) begin
      tick();
      chk("wait_cli_wait", bus.cli_wait, 3'b111);
      chk("wait_wr_src", bus.sdram_wr & ~bus.cli_wr[1], 0);
    end
    bus.sdram_wait = 1'b0;
    wait_idle(600);
    check_log(30, 0);
    // frame 3: client 0 raises its last write together with done
    late = 1;
    log_q.delete();
    pulse();
    chk("f3_flip", frame_flip, 0);
    c = 0;
    while (!(bus.cli_done[0] && bus.cli_wr[0]) && c < 200) begin
      tick();
      c++;
    end
    chk("late_seen", bus.cli_done[0] && bus.cli_wr[0], 1);
    c = 0;
    while (bus.cli_wr[0] && c < 20) begin
      chk("late_hold", bus.cli_wait, 3'b110);
      tick();
      c++;
    end
    chk("late_wr_drop", bus.cli_wr[0], 0);
    chk("late_advance", bus.cli_wait, 3'b111);
    chk("late_busy", busy, 1);
    tick();
    chk("late_grant1", bus.cli_wait, 3'b101);
    late = 0;
    wait_idle(600);
    check_log(30, 0);
    // frame 4: client 1 never finishes and is skipped by the watchdog
    hang1 = 1;
    log_q.delete();
    pulse();
    chk("f4_flip", frame_flip, 1);
    c = 0;
    n1 = 0;
    while (busy && c < 1000) begin
      tick();
      c++;
      if (busy && !bus.cli_wait[1]) n1++;
    end
    chk("to_run_cycles", n1, 100);
    chk("to_cnt", timeout_cnt, 1);
    chk("to_idle", busy, 0);
    check_log(20, 1);
    hang1 = 0;
    // frame 5: new_frame while client 2 draws
    log_q.delete();
    pulse();
    chk("f5_flip", frame_flip, 0);
    wait_grant(2);
    tick();
    pulse();
    chk("ovr_cnt", overrun_cnt, 1);
    chk("ovr_no_flip", frame_flip, 0);
    chk("ovr_busy", busy, 1);
    tick();
    chk("ovr_cnt_hold", overrun_cnt, 1);
    wait_idle(600);
    chk("ovr_flip_done", frame_flip, 0);
    check_log(30, 0);
    log_q.delete();
    pulse();
    chk("f6_flip", frame_flip, 1);
    chk("f6_kick_nf", bus.cli_new_frame, 3'b111);
    // reset while a write is on the port
    c = 0;
    while (!bus.sdram_wr && c < 200) begin
      tick();
      c++;
    end
    chk("mid_wr_seen", bus.sdram_wr, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_wr", bus.sdram_wr, 0);
    chk("arst_flip", frame_flip, 0);
    chk("arst_busy", busy, 0);
    chk("arst_cli_wait", bus.cli_wait, 3'b111);
    chk("arst_ovr", overrun_cnt, 0);
    chk("arst_tmo", timeout_cnt, 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_nf", bus.cli_new_frame, 3'b000);
    // overrun counter saturation
    new_frame = 1'b1;
    repeat (300) tick();
    new_frame = 1'b0;
    chk("ovr_sat", overrun_cnt, 8'hFF);
    tick();
    chk("ovr_sat_hold", overrun_cnt, 8'hFF);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/draw_scheduler.md
Name: draw_scheduler

Overview:
- Per-frame sequencer and SDRAM write-port arbiter for the sprite draw clients: the note drawer, the score/combo drawer and the judgement drawer.
- Owns the double-buffer `frame_flip` bit.
- Starts each client in turn and grants it exclusive use of the single SDRAM write port.
- Flips the buffer at the next `new_frame` once every client reports done.
- Sits between the draw clients and the SDRAM controller write interface.

Parameters:
- `N_CLI`, 3, number of draw clients; client 0 has the highest order and runs first.
- `TIMEOUT`, 20'd400000, maximum cycles one client may hold the grant before it is skipped.
- `CNT_W`, 8, width of the overrun and timeout event counters.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `new_frame`  in  1  single-cycle pulse, synchronous to `clk`, marking the start of the display frame.
- `sdram_wait`  in  1  SDRAM controller cannot accept writes.
- `sdram_ac`  in  1  SDRAM controller acknowledges the current write.
- `cli_wr`  in  N_CLI  per-client write request.
- `cli_addr`  in  N_CLI×22  per-client SDRAM word address.
- `cli_data`  in  N_CLI×128  per-client write data.
- `cli_be`  in  N_CLI×16  per-client byte enables.
- `cli_done`  in  N_CLI  per-client frame-complete level.
- `cli_new_frame`  out  N_CLI  per-client start pulse.
- `cli_wait`  out  N_CLI  per-client gated wait.
- `cli_ac`  out  N_CLI  per-client gated acknowledge.
- `sdram_wr`  out  1  write strobe to the controller.
- `sdram_addr`  out  22  write address to the controller.
- `sdram_data`  out  128  write data to the controller.
- `sdram_be`  out  16  byte enables to the controller.
- `frame_flip`  out  1  selects the back buffer; 0 selects the 22'h100000 base, 1 selects the 22'h200000 base.
- `busy`  out  1  a frame's draw is in progress.
- `overrun_cnt`  out  CNT_W  count of frames where `new_frame` arrived before all clients finished.
- `timeout_cnt`  out  CNT_W  count of clients skipped by the watchdog.

Behaviour:
- Reset values:
  - state IDLE, grant 0, `frame_flip` 0, counters 0.
  - All outputs 0, except `cli_wait`, which is all 1s.
- States: IDLE, KICK, RUN, ADVANCE, DONE.
- IDLE: on `new_frame`, go to KICK. No flip on the first frame after reset.
- KICK (1 cycle):
  - `cli_new_frame` = all 1s; grant=0; watchdog cleared.
  - Next state RUN.
  - Clients see the start pulse exactly one cycle after `new_frame`.
- RUN:
  - `sdram_wr`/`addr`/`data`/`be` = `cli_*[grant]`, forwarded combinationally with zero latency.
  - `cli_wait[i]` = `sdram_wait` | (state!=RUN) | (grant!=i).
  - `cli_ac[i]` = `sdram_ac` & (state==RUN) & (grant==i).
  - Watchdog increments every RUN cycle.
  - Go to ADVANCE when `cli_done[grant]`=1 and `cli_wr[grant]`=0.
  - Also go to ADVANCE when the watchdog reaches TIMEOUT-1 and `cli_wr[grant]`=0; this increments `timeout_cnt`.
  - Grant never changes while `cli_wr[grant]`=1. A write in flight always completes to `sdram_ac`.
- ADVANCE (1 cycle):
  - Outputs idle, `sdram_wr`=0.
  - If grant==N_CLI-1, go to DONE. Otherwise grant+1, watchdog cleared, back to RUN.
- DONE:
  - `busy`=0, all `cli_wait` high.
  - On `new_frame`: toggle `frame_flip` in the same edge, then go to KICK.
- `busy` = 1 in KICK, RUN and ADVANCE.
- Overrun: `new_frame` while in KICK, RUN or ADVANCE:
  - `overrun_cnt`+1 (saturating at 2^CNT_W-1).
  - No flip, no restart; drawing continues.
  - DONE then waits for the next `new_frame`, so the frame is dropped, never torn.
- Overrun at the same moment as advancing into DONE: the pulse counts as an overrun and is not acted on by DONE.
- `cli_done` of a non-granted client is ignored.
- Both counters saturate.
- Reset mid-write: `sdram_wr` drops immediately (asynchronous) and the state returns to IDLE.

Decomposition:
- Package `draw_pkg`:
  - state enum.
  - `WRADDR_OFFSET0`=22'h100000 and `WRADDR_OFFSET1`=22'h200000.
  - `TRANSPARENT`=8'hFF.
  - client index constants `CLI_NOTE`=0, `CLI_SCORE`=1, `CLI_JUDGE`=2.
- Sub-module `draw_watchdog`: loadable cycle counter with clear, enable and an expiry flag, width derived from TIMEOUT.
- The port mux is kept inline.

Test Plan:
- Reset, then `new_frame`, with each client asserting done after 10 writes and `sdram_ac` 2 cycles after each `wr` → `cli_new_frame`=3'b111 at T+1. Exactly 30 writes appear in order client 0, then 1, then 2. `busy` falls afterwards. `frame_flip` stays 0 until the second `new_frame`, where it becomes 1.
- `sdram_wait` held high for 50 cycles during client 1's grant → `sdram_wr` never goes high without client 1's request, and `cli_wait`=3'b111 throughout. Writes resume once wait drops, with no lost or duplicated address.
- Client 0 raises `cli_wr` on its done cycle → grant is held until `sdram_ac`, and ADVANCE is entered the cycle after.
- Client 1 never asserts done, with TIMEOUT=100 → skipped after 100 RUN cycles. `timeout_cnt`=1, client 2 runs, and the frame completes.
- `new_frame` arrives while client 2 is running → `overrun_cnt`=1, no flip at that pulse, DONE is reached, and the next `new_frame` flips `frame_flip`.
- Reset asserted mid-RUN with `sdram_wr`=1 → `sdram_wr`=0 and `frame_flip`=0 asynchronously, then IDLE.
